dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (cpu = port 0, dbg = port 1).
// Each access takes IDLE -> ACCESS -> DONE; grant, error and read data belong to the selected port.
module dmem_arbiter #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_di,
    output logic        mem_we,
    input  logic [31:0] mem_do,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t      state;
    state_t      state_next;
    logic        sel;
    logic        last_gnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        cpu_err_q;
    logic        dbg_err_q;
    logic        in_range;
    logic        any_req;
    logic        winner;

    assign in_range = (addr_q < 32'(MEM_DEPTH));
    assign any_req  = cpu_req | dbg_req;

    // On a tie, round-robin hands the access to whichever port was not served last.
    always_comb begin
        winner = PORT_CPU;
        if (cpu_req && dbg_req) begin
            winner = FIXED_PRIO ? PORT_CPU : ~last_gnt;
        end else if (dbg_req) begin
            winner = PORT_DBG;
        end
    end

    always_comb begin
        state_next = state;
        mem_a      = 32'h0;
        mem_di     = 32'h0;
        mem_we     = 1'b0;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_err    = 1'b0;
        dbg_err    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                busy       = 1'b1;
                mem_a      = addr_q;
                mem_di     = wdata_q;
                // A reset landing on the access cycle must not commit the write.
                mem_we     = we_q & in_range & ~rst;
                state_next = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (sel == PORT_CPU) begin
                    cpu_gnt = 1'b1;
                    cpu_err = cpu_err_q;
                end else begin
                    dbg_gnt = 1'b1;
                    dbg_err = dbg_err_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= PORT_CPU;
            last_gnt  <= PORT_DBG;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cpu_rdata <= 32'h0;
            dbg_rdata <= 32'h0;
            cpu_err_q <= 1'b0;
            dbg_err_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel     <= winner;
                        we_q    <= (winner == PORT_CPU) ? cpu_we    : dbg_we;
                        addr_q  <= (winner == PORT_CPU) ? cpu_addr  : dbg_addr;
                        wdata_q <= (winner == PORT_CPU) ? cpu_wdata : dbg_wdata;
                    end
                end
                ACCESS: begin
                    if (sel == PORT_CPU) begin
                        cpu_rdata <= in_range ? mem_do : 32'h0;
                        cpu_err_q <= ~in_range;
                    end else begin
                        dbg_rdata <= in_range ? mem_do : 32'h0;
                        dbg_err_q <= ~in_range;
                    end
                end
                DONE: begin
                    last_gnt <= sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives a round-robin instance (u_rr) and a fixed-priority instance (u_fp) with random traffic,
// each backed by its own memory, against a cycle-level model of the access protocol.
module tb_dmem_arbiter;

    localparam int DEPTH = 256;
    localparam int N_CYC = 3000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       preload;
    logic [1:0]       cpu_req, cpu_we, cpu_gnt, cpu_err;
    logic [1:0]       dbg_req, dbg_we, dbg_gnt, dbg_err;
    logic [1:0][31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0][31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [1:0][31:0] mem_a, mem_di, mem_do;
    logic [1:0]       mem_we, busy;
    logic [31:0]      mem [2][DEPTH];

    dmem_arbiter #(.MEM_DEPTH(DEPTH), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst[0]),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .cpu_rdata(cpu_rdata[0]), .cpu_err(cpu_err[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_gnt(dbg_gnt[0]), .dbg_rdata(dbg_rdata[0]), .dbg_err(dbg_err[0]),
        .mem_a(mem_a[0]), .mem_di(mem_di[0]), .mem_we(mem_we[0]), .mem_do(mem_do[0]), .busy(busy[0])
    );

    dmem_arbiter #(.MEM_DEPTH(DEPTH), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst[1]),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .cpu_rdata(cpu_rdata[1]), .cpu_err(cpu_err[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_gnt(dbg_gnt[1]), .dbg_rdata(dbg_rdata[1]), .dbg_err(dbg_err[1]),
        .mem_a(mem_a[1]), .mem_di(mem_di[1]), .mem_we(mem_we[1]), .mem_do(mem_do[1]), .busy(busy[1])
    );

    function automatic logic [31:0] init_word(int k);
        logic [3:0] w;
        w = 4'(k / 4);
        if (k == 0) return 32'hA000_00AA;
        if ((k % 4 == 0) && (k < 64)) return {w, 20'h0, w, w};
        return (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Memories: combinational read, write on the rising edge.
    assign mem_do[0] = (mem_a[0] < DEPTH) ? mem[0][mem_a[0][7:0]] : 32'h0;
    assign mem_do[1] = (mem_a[1] < DEPTH) ? mem[1][mem_a[1][7:0]] : 32'h0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload[i]) begin
                for (int k = 0; k < DEPTH; k++) mem[i][k] <= init_word(k);
            end else if (mem_we[i] && (mem_a[i] < DEPTH)) begin
                mem[i][mem_a[i][7:0]] <= mem_di[i];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [2][DEPTH];
    logic [31:0] exp_rd  [2][2];
    bit          pend [2];
    int          ecyc [2];
    int          free_cyc [2];
    bit          eport [2];
    op_t         eop [2];
    bit          ein [2];
    logic [31:0] eold [2];
    bit          last [2];
    bit          decided [2];
    bit          g_cpu [2];
    bit          g_dbg [2];
    bit          rst_once;
    op_t         cpu_dq[$];
    op_t         dbg_dq[$];
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        int  r;
        r       = $urandom_range(0, 15);
        o.we    = 1'($urandom_range(0, 1));
        o.wdata = $urandom;
        case (r)
            0:       o.addr = 32'(DEPTH);
            1:       o.addr = {1'b1, 31'($urandom)};
            2:       o.addr = 32'(DEPTH - 1);
            3:       o.addr = 32'($urandom_range(DEPTH, 4096));
            default: o.addr = 32'($urandom_range(0, 15) * 4);
        endcase
        return o;
    endfunction

    task automatic model_step(input int i, input int c);
        bit          access, done, xwe, xcg, xdg;
        logic [31:0] xa, xd;
        string       t;
        access = pend[i] && (c == ecyc[i] - 1);
        done   = pend[i] && (c == ecyc[i]);
        xa     = access ? eop[i].addr  : 32'h0;
        xd     = access ? eop[i].wdata : 32'h0;
        xwe    = access && eop[i].we && ein[i] && !rst[i];
        xcg    = done && !eport[i];
        xdg    = done && eport[i];
        t      = $sformatf("u%0d/c%0d", i, c);
        check({t, " mem_we"},    32'(mem_we[i]),  32'(xwe));
        check({t, " mem_a"},     mem_a[i],        xa);
        check({t, " mem_di"},    mem_di[i],       xd);
        check({t, " busy"},      32'(busy[i]),    32'(access || done));
        check({t, " cpu_gnt"},   32'(cpu_gnt[i]), 32'(xcg));
        check({t, " dbg_gnt"},   32'(dbg_gnt[i]), 32'(xdg));
        check({t, " cpu_err"},   32'(cpu_err[i]), 32'(xcg && !ein[i]));
        check({t, " dbg_err"},   32'(dbg_err[i]), 32'(xdg && !ein[i]));
        check({t, " cpu_rdata"}, cpu_rdata[i],    exp_rd[i][0]);
        check({t, " dbg_rdata"}, dbg_rdata[i],    exp_rd[i][1]);

        g_cpu[i]   = cpu_gnt[i];
        g_dbg[i]   = dbg_gnt[i];
        decided[i] = 1'b0;
        if (access && !rst[i]) begin
            if (eop[i].we && ein[i]) ref_mem[i][eop[i].addr[7:0]] = eop[i].wdata;
            exp_rd[i][eport[i]] = eold[i];
        end
        if (done) begin
            pend[i] = 1'b0;
            last[i] = eport[i];
        end
        if (rst[i]) begin
            pend[i]      = 1'b0;
            last[i]      = 1'b1;
            exp_rd[i][0] = 32'h0;
            exp_rd[i][1] = 32'h0;
            free_cyc[i]  = c + 1;
        end else if (!pend[i] && (c >= free_cyc[i]) && (cpu_req[i] || dbg_req[i])) begin
            if (cpu_req[i] && dbg_req[i]) eport[i] = (i == 1) ? 1'b0 : !last[i];
            else                          eport[i] = dbg_req[i];
            eop[i] = eport[i] ? '{we: dbg_we[i], addr: dbg_addr[i], wdata: dbg_wdata[i]}
                              : '{we: cpu_we[i], addr: cpu_addr[i], wdata: cpu_wdata[i]};
            ein[i]      = (eop[i].addr < DEPTH);
            eold[i]     = ein[i] ? ref_mem[i][eop[i].addr[7:0]] : 32'h0;
            pend[i]     = 1'b1;
            ecyc[i]     = c + 2;
            free_cyc[i] = c + 3;
            decided[i]  = 1'b1;
        end
    endtask

    task automatic drive(input int i, input int c);
        op_t o;
        bit  go;
        bit  hit20;
        if (!cpu_req[i] || g_cpu[i]) begin
            if (i == 0 && cpu_dq.size() > 0) begin
                o  = cpu_dq.pop_front();
                go = 1'b1;
            end else begin
                o  = rand_op();
                go = cpu_req[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            end
            cpu_req[i] = go; cpu_we[i] = o.we; cpu_addr[i] = o.addr; cpu_wdata[i] = o.wdata;
        end
        if (!dbg_req[i] || g_dbg[i]) begin
            if (i == 0 && dbg_dq.size() > 0) begin
                o  = dbg_dq.pop_front();
                go = 1'b1;
            end else begin
                o  = rand_op();
                go = dbg_req[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            end
            dbg_req[i] = go; dbg_we[i] = o.we; dbg_addr[i] = o.addr; dbg_wdata[i] = o.wdata;
        end
        // Reset is only ever injected into the ACCESS cycle that follows an arbitration.
        hit20  = !rst_once && (i == 0) && eport[i] && eop[i].we && (eop[i].addr == 32'h20);
        rst[i] = decided[i] && (hit20 || ((c > 100) && ($urandom_range(0, 11) == 0)));
        if (decided[i] && hit20) rst_once = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_once = 1'b0;
        rst      = 2'b11;
        preload  = 2'b11;
        cpu_req  = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req  = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[i][k] = init_word(k);
            pend[i] = 1'b0; last[i] = 1'b1; free_cyc[i] = 0; ecyc[i] = -10;
            eport[i] = 1'b0; eop[i] = '0; ein[i] = 1'b1; eold[i] = 32'h0;
            exp_rd[i][0] = 32'h0; exp_rd[i][1] = 32'h0;
            decided[i] = 1'b0; g_cpu[i] = 1'b0; g_dbg[i] = 1'b0;
        end
        cpu_dq.push_back('{we: 1'b0, addr: 32'h08,  wdata: 32'h0});
        cpu_dq.push_back('{we: 1'b0, addr: 32'h14,  wdata: 32'h0});
        cpu_dq.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'h1234_5678});
        cpu_dq.push_back('{we: 1'b0, addr: 32'h00,  wdata: 32'h0});
        cpu_dq.push_back('{we: 1'b0, addr: 32'h04,  wdata: 32'h0});
        cpu_dq.push_back('{we: 1'b0, addr: 32'h0C,  wdata: 32'h0});
        dbg_dq.push_back('{we: 1'b1, addr: 32'h14,  wdata: 32'hDEAD_BEEF});
        dbg_dq.push_back('{we: 1'b1, addr: 32'h20,  wdata: 32'h5555_5555});

        repeat (3) @(posedge clk);
        #1;
        rst     = 2'b00;
        preload = 2'b00;

        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            model_step(0, c);
            model_step(1, c);
            @(posedge clk);
            #1;
            drive(0, c);
            drive(1, c);
        end

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                check($sformatf("u%0d mem[%0d]", i, k), mem[i][k], ref_mem[i][k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
